// File: rtl/bsg_link_sdr_upstream_multi_if.sv
// Core-side flit handshake plus credit token and the multi-channel SDR output bus.
// The slave modport is the upstream link itself; master is the core/PHY side driving it.
interface bsg_link_sdr_upstream_multi_if #(
  parameter int unsigned width_p         = 64,
  parameter int unsigned num_channels_p  = 2,
  parameter int unsigned channel_width_p = 8,
  parameter int unsigned max_credits_p   = 16
);
  localparam int unsigned io_w_lp     = num_channels_p * channel_width_p;
  localparam int unsigned credit_w_lp = $clog2(max_credits_p + 1);

  logic [width_p-1:0]        core_data_i;
  logic                      core_valid_i;
  logic                      core_ready_o;
  logic                      token_i;
  logic [io_w_lp-1:0]        io_data_o;
  logic [num_channels_p-1:0] io_valid_o;
  logic [credit_w_lp-1:0]    credit_o;
  logic                      overflow_o;

  modport master (
    output core_data_i, core_valid_i, token_i,
    input  core_ready_o, io_data_o, io_valid_o, credit_o, overflow_o
  );

  modport slave (
    input  core_data_i, core_valid_i, token_i,
    output core_ready_o, io_data_o, io_valid_o, credit_o, overflow_o
  );
endinterface

// File: rtl/bsg_link_sdr_upstream_multi.sv
// Credit-based SDR upstream link: buffers core flits in a 2-entry FIFO and
// serializes each one over num_channels_p parallel channels in beats_lp beats.
module bsg_link_sdr_upstream_multi #(
  parameter int unsigned width_p                = 64,
  parameter int unsigned num_channels_p         = 2,
  parameter int unsigned channel_width_p        = 8,
  parameter int unsigned max_credits_p          = 16,
  parameter int unsigned lg_credit_decimation_p = 2
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_link_sdr_upstream_multi_if.slave link
);
  localparam int unsigned io_w_lp          = num_channels_p * channel_width_p;
  localparam int unsigned beats_lp         = width_p / io_w_lp;
  localparam int unsigned beat_w_lp        = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int unsigned credit_w_lp      = $clog2(max_credits_p + 1);
  localparam int unsigned sum_w_lp         = credit_w_lp + 1;
  localparam int unsigned token_credits_lp = 1 << lg_credit_decimation_p;

  typedef enum logic {IDLE_S = 1'b0, SEND_S = 1'b1} state_e;

  // FIFO storage and bookkeeping
  logic [width_p-1:0] mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q, count_d;
  logic               fifo_full, fifo_empty, fifo_write;
  logic [width_p-1:0] fifo_head;

  // Serializer
  state_e                    state_q, state_d;
  logic [beat_w_lp-1:0]      beat_q, beat_d;
  logic [width_p-1:0]        flit_q, flit_d;
  logic [io_w_lp-1:0]        io_data_q, io_data_d;
  logic [num_channels_p-1:0] io_valid_q, io_valid_d;
  logic                      last_beat, slot_free, launch;

  // Credits
  logic [credit_w_lp-1:0] credit_q, credit_d;
  logic [sum_w_lp-1:0]    credit_sum;
  logic                   credit_over;
  logic                   overflow_q, overflow_d;

  assign fifo_full  = (count_q == 2'd2);
  assign fifo_empty = (count_q == 2'd0);
  assign fifo_write = link.core_valid_i & ~fifo_full;
  assign fifo_head  = mem_q[rd_ptr_q];
  assign count_d    = count_q + 2'(fifo_write) - 2'(launch);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (fifo_write) begin
        mem_q[wr_ptr_q] <= link.core_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (launch) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // A new flit may start only when the output slot is free; eligibility uses registered credit.
  assign last_beat = (beat_q == beat_w_lp'(beats_lp - 1));
  assign slot_free = (state_q == IDLE_S) | last_beat;
  assign launch    = slot_free & ~fifo_empty & (credit_q != '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE_S;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE_S: begin
        if (launch) begin
          state_d = SEND_S;
          beat_d  = '0;
        end
      end
      SEND_S: begin
        if (last_beat) begin
          state_d = launch ? SEND_S : IDLE_S;
          beat_d  = '0;
        end else begin
          beat_d = beat_w_lp'(beat_q + 1'b1);
        end
      end
      default: begin
        state_d = IDLE_S;
        beat_d  = '0;
      end
    endcase
  end

  // Beat 0 comes straight from the FIFO head; later beats shift out of flit_q.
  always_comb begin
    io_data_d  = '0;
    io_valid_d = '0;
    flit_d     = flit_q;
    if (launch) begin
      io_data_d  = fifo_head[io_w_lp-1:0];
      io_valid_d = '1;
      flit_d     = fifo_head >> io_w_lp;
    end else if ((state_q == SEND_S) && !last_beat) begin
      io_data_d  = flit_q[io_w_lp-1:0];
      io_valid_d = '1;
      flit_d     = flit_q >> io_w_lp;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      flit_q     <= '0;
      io_data_q  <= '0;
      io_valid_q <= '0;
    end else begin
      flit_q     <= flit_d;
      io_data_q  <= io_data_d;
      io_valid_q <= io_valid_d;
    end
  end

  // Sum is formed one bit wider so an over-return is detected before clamping.
  always_comb begin
    credit_sum  = sum_w_lp'(credit_q) - sum_w_lp'(launch)
                + (link.token_i ? sum_w_lp'(token_credits_lp) : sum_w_lp'(0));
    credit_over = (credit_sum > sum_w_lp'(max_credits_p));
    credit_d    = credit_over ? credit_w_lp'(max_credits_p) : credit_w_lp'(credit_sum);
    overflow_d  = overflow_q | credit_over;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credit_q   <= credit_w_lp'(max_credits_p);
      overflow_q <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  assign link.core_ready_o = ~fifo_full;
  assign link.io_data_o    = io_data_q;
  assign link.io_valid_o   = io_valid_q;
  assign link.credit_o     = credit_q;
  assign link.overflow_o   = overflow_q;

endmodule

// File: tb/tb_bsg_link_sdr_upstream_multi.sv
// Directed and random stimulus for bsg_link_sdr_upstream_multi, checked against a
// queue-based flit/credit model of the link.
module tb_bsg_link_sdr_upstream_multi;
  localparam int unsigned W     = 64;
  localparam int unsigned NC    = 2;
  localparam int unsigned CW    = 8;
  localparam int unsigned MC    = 16;
  localparam int unsigned LG    = 2;
  localparam int unsigned IOW   = NC * CW;
  localparam int          BEATS = W / IOW;
  localparam int          TOK   = 1 << LG;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  bsg_link_sdr_upstream_multi_if #(
    .width_p(W), .num_channels_p(NC), .channel_width_p(CW), .max_credits_p(MC)
  ) link ();

  bsg_link_sdr_upstream_multi #(
    .width_p(W), .num_channels_p(NC), .channel_width_p(CW),
    .max_credits_p(MC), .lg_credit_decimation_p(LG)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .link     (link.slave)
  );

  always #5 clk = ~clk;

  // Model: pending flits, the flit on the wire and which beat of it is shown (-1 = idle).
  logic [W-1:0] mq [$];
  logic [W-1:0] cur_m;
  int           idx_m;
  int           credit_m;
  bit           ovf_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    cur_m    = '0;
    idx_m    = -1;
    credit_m = MC;
    ovf_m    = 1'b0;
  endtask

  task automatic do_reset();
    link.core_valid_i = 1'b0;
    link.core_data_i  = '0;
    link.token_i      = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_io_valid", 64'(link.io_valid_o), 64'(0));
    chk("rst_io_data",  64'(link.io_data_o),  64'(0));
    chk("rst_credit",   64'(link.credit_o),   64'(MC));
    chk("rst_overflow", 64'(link.overflow_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs, step the model, then compare all outputs after the edge.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit tok, output bit acc);
    bit rdy, slot, lau;
    int c;
    logic [IOW-1:0] exp_data;
    link.core_valid_i = v;
    link.core_data_i  = d;
    link.token_i      = tok;
    rdy = (mq.size() < 2);
    #1;
    chk("core_ready", 64'(link.core_ready_o), 64'(rdy));
    slot = (idx_m < 0) || (idx_m == BEATS - 1);
    lau  = slot && (mq.size() > 0) && (credit_m > 0);
    if (lau) begin
      cur_m = mq.pop_front();
      idx_m = 0;
    end else if (idx_m >= 0 && idx_m < BEATS - 1) begin
      idx_m++;
    end else begin
      idx_m = -1;
    end
    c = credit_m - int'(lau) + (tok ? TOK : 0);
    if (c > MC) begin
      c = MC;
      ovf_m = 1'b1;
    end
    credit_m = c;
    acc = v && rdy;
    if (acc) mq.push_back(d);
    @(posedge clk);
    #1;
    exp_data = (idx_m < 0) ? '0 : IOW'(cur_m >> (idx_m * IOW));
    chk("io_data",  64'(link.io_data_o),  64'(exp_data));
    chk("io_valid", 64'(link.io_valid_o), (idx_m < 0) ? 64'(0) : 64'({NC{1'b1}}));
    chk("credit",   64'(link.credit_o),   64'(credit_m));
    chk("overflow", 64'(link.overflow_o), 64'(ovf_m));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, acc);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 200 && (idx_m >= 0 || mq.size() > 0); i++) cycle(1'b0, '0, 1'b0, acc);
    chk("drain_done", 64'(idx_m < 0 && mq.size() == 0), 64'(1));
  endtask

  initial begin
    bit acc;
    int pushed, vcnt;
    bit saw_low;
    link.core_valid_i = 1'b0;
    link.core_data_i  = '0;
    link.token_i      = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Single flit: four beats of 16 bits, least-significant first.
    cycle(1'b1, 64'h0807_0605_0403_0201, 1'b0, acc);
    chk("single_pre_valid", 64'(link.io_valid_o), 64'(0));
    cycle(1'b0, '0, 1'b0, acc);
    chk("single_b0", 64'(link.io_data_o), 64'h0201);
    chk("single_v0", 64'(link.io_valid_o), 64'h3);
    chk("single_cr", 64'(link.credit_o), 64'd15);
    cycle(1'b0, '0, 1'b0, acc);
    chk("single_b1", 64'(link.io_data_o), 64'h0403);
    cycle(1'b0, '0, 1'b0, acc);
    chk("single_b2", 64'(link.io_data_o), 64'h0605);
    cycle(1'b0, '0, 1'b0, acc);
    chk("single_b3", 64'(link.io_data_o), 64'h0807);
    cycle(1'b0, '0, 1'b0, acc);
    chk("single_end", 64'(link.io_valid_o), 64'(0));

    // 17 flits with no tokens: 16 go out back-to-back, the 17th waits.
    do_reset();
    pushed = 0; vcnt = 0; saw_low = 1'b0;
    for (int i = 0; i < 90; i++) begin
      if (link.core_ready_o === 1'b0) saw_low = 1'b1;
      cycle(pushed < 17, {$urandom, $urandom}, 1'b0, acc);
      if (acc) pushed++;
      if (link.io_valid_o === 2'b11) vcnt++;
    end
    chk("burst_pushed", 64'(pushed), 64'd17);
    chk("burst_valid_cycles", 64'(vcnt), 64'd64);
    chk("burst_credit", 64'(link.credit_o), 64'd0);
    chk("burst_ready_fell", 64'(saw_low), 64'd1);

    // Token at zero credit does not launch in its own cycle.
    cycle(1'b0, '0, 1'b1, acc);
    chk("tok0_valid", 64'(link.io_valid_o), 64'(0));
    chk("tok0_credit", 64'(link.credit_o), 64'd4);
    cycle(1'b0, '0, 1'b0, acc);
    chk("tok0_launch", 64'(link.io_valid_o), 64'h3);
    chk("tok0_credit2", 64'(link.credit_o), 64'd3);
    drain();

    // Over-return: token at 14 with no launch.
    do_reset();
    cycle(1'b1, {$urandom, $urandom}, 1'b0, acc);
    cycle(1'b1, {$urandom, $urandom}, 1'b0, acc);
    drain();
    chk("ovf_pre_credit", 64'(link.credit_o), 64'd14);
    cycle(1'b0, '0, 1'b1, acc);
    chk("ovf_credit", 64'(link.credit_o), 64'd16);
    chk("ovf_flag", 64'(link.overflow_o), 64'd1);
    idle(3);
    chk("ovf_sticky", 64'(link.overflow_o), 64'd1);

    // Launch and token together at credit 5.
    do_reset();
    pushed = 0;
    for (int i = 0; i < 100 && pushed < 11; i++) begin
      cycle(1'b1, {$urandom, $urandom}, 1'b0, acc);
      if (acc) pushed++;
    end
    drain();
    chk("lt_pre_credit", 64'(link.credit_o), 64'd5);
    cycle(1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, acc);
    cycle(1'b0, '0, 1'b1, acc);
    chk("lt_credit", 64'(link.credit_o), 64'd8);
    chk("lt_beat0", 64'(link.io_data_o), 64'hF00D);
    drain();

    // Asynchronous reset in the middle of beat 2 with a flit still queued.
    do_reset();
    cycle(1'b1, 64'h1111_2222_3333_4444, 1'b0, acc);
    cycle(1'b1, 64'h5555_6666_7777_8888, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, acc);
    cycle(1'b0, '0, 1'b0, acc);
    chk("mid_beat2", 64'(link.io_data_o), 64'h2222);
    #2;
    do_reset();
    idle(6);

    // Random traffic with sparse tokens.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) != 0), {$urandom, $urandom}, ($urandom_range(0, 5) == 0), acc);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bsg_link_sdr_upstream_multi.md
BSG_LINK_SDR_UPSTREAM_MULTI -- requirements
Module: bsg_link_sdr_upstream_multi

Interface
REQ-001 SHALL have parameter width_p, default 64, core flit width in bits.
REQ-002 SHALL have parameter num_channels_p, default 2, number of physical output channels.
REQ-003 SHALL have parameter channel_width_p, default 8, data bits per channel per beat.
REQ-004 SHALL have parameter max_credits_p, default 16, receiver buffer depth in flits.
REQ-005 SHALL have parameter lg_credit_decimation_p, default 2, log2 of credits returned per token pulse.
REQ-006 SHALL derive beats_lp = width_p/(num_channels_p*channel_width_p); default is 4.
REQ-007 SHALL have port clk_i, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-008 SHALL have port reset_n_i, input, 1, reset, asynchronous and active-low.
REQ-009 SHALL have port core_data_i, input, width_p, flit payload.
REQ-010 SHALL have port core_valid_i, input, 1, flit offered.
REQ-011 SHALL have port core_ready_o, output, 1, flit accepted when core_valid_i & core_ready_o.
REQ-012 SHALL have port token_i, input, 1, one-cycle pulse returning 2^lg_credit_decimation_p credits.
REQ-013 SHALL have port io_data_o, output, num_channels_p*channel_width_p, registered beat data; channel c occupies slice c.
REQ-014 SHALL have port io_valid_o, output, num_channels_p, registered per-channel beat valid.
REQ-015 SHALL have port credit_o, output, $clog2(max_credits_p+1), current credit count.
REQ-016 SHALL have port overflow_o, output, 1, sticky credit over-return error.

Function
REQ-017 SHALL hold accepted flits in a 2-entry FIFO; core_ready_o = FIFO not full, combinationally independent of core_valid_i.
REQ-018 SHALL run a serializer FSM with states IDLE and SEND plus a beat counter 0..beats_lp-1.
REQ-019 SHALL launch a flit (IDLE->SEND, or SEND on last beat staying SEND) when FIFO is non-empty and credit_o >= 1; launch pops the FIFO and consumes exactly 1 credit.
REQ-020 SHALL evaluate launch eligibility on the registered credit_o value; a token_i in the same cycle SHALL NOT enable a launch at credit_o = 0.
REQ-021 SHALL drive beat k onto channel c as core_data bits [(k*num_channels_p+c)*channel_width_p +: channel_width_p]; beat 0 carries the least-significant slices.
REQ-022 SHALL present beat 0 on io_data_o/io_valid_o the cycle after launch; a flit written into an empty FIFO at edge t with credit available SHALL appear as beat 0 at edge t+1, last beat at t+beats_lp.
REQ-023 SHALL sustain back-to-back flits with no idle cycle when the next launch condition holds during the last beat.
REQ-024 SHALL drive all io_valid_o bits identically and SHALL drive io_data_o to zero whenever io_valid_o is 0.
REQ-025 SHALL return to IDLE after the last beat when no launch is possible; a flit in progress SHALL always complete regardless of credit.
REQ-026 SHALL update credit_o each cycle as credit_o - launch + (token_i ? 2^lg_credit_decimation_p : 0), computed at full width before clamping.
REQ-027 SHALL clamp credit_o to max_credits_p if the sum exceeds it, and set overflow_o to 1 until reset.
REQ-028 SHALL accept a FIFO write and pop in the same cycle when full (pop frees the entry) only via ready already being 0; write while full SHALL NOT occur.
REQ-029 SHALL require width_p to be divisible by num_channels_p*channel_width_p and max_credits_p to be a multiple of 2^lg_credit_decimation_p; other values are illegal.

Reset
REQ-030 SHALL, on reset_n_i low, immediately (asynchronously) clear FIFO, FSM to IDLE, beat counter 0, io_valid_o 0, io_data_o 0, overflow_o 0, credit_o max_credits_p.
REQ-031 SHALL discard any partially sent flit on reset mid-operation; core_ready_o SHALL be 1 from the first clock edge after reset_n_i deasserts.

Verification
REQ-032 Single flit 64'h0807_0605_0403_0201 after reset -> io_data_o = 16'h0201,16'h0403,16'h0605,16'h0807 on 4 consecutive cycles, io_valid_o = 2'b11, credit_o 16->15.
REQ-033 17 flits continuously, no token -> 16 sent back-to-back (64 valid cycles), 17th held, credit_o = 0, core_ready_o falls once FIFO holds 2.
REQ-034 At credit_o = 0 pulse token_i -> no launch that cycle, credit_o = 4 next cycle, launch the following cycle.
REQ-035 Token at credit_o = 14 with no launch -> credit_o = 16, overflow_o = 1 and stays 1.
REQ-036 Launch and token same cycle at credit_o = 5 -> credit_o = 8.
REQ-037 reset_n_i low during beat 2 -> io_valid_o 0 without a clock edge, credit_o = 16, FIFO empty.
